// File: rtl/dvi_capture.sv
// dvi_capture: receive-side DVI pixel capture into a framebuffer write port,
// with line/frame geometry checking and sync timing measurement.
module dvi_capture #(
  parameter int hori_visible_area = 1024,
  parameter int vert_visible_area = 768,
  parameter bit sync_polarity     = 1'b0,
  parameter int RAM_width         = 1,
  parameter int RAM_depth         = 786432,
  parameter int RAM_depth_bits    = $clog2(RAM_depth)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      vid_de,
  input  logic                      vid_h,
  input  logic                      vid_v,
  input  logic [23:0]               vid_data,
  input  logic                      capture_en,
  input  logic                      err_clear,
  output logic [RAM_depth_bits-1:0] framebuffer_addr,
  output logic [RAM_width-1:0]      framebuffer_wdata,
  output logic                      framebuffer_we,
  output logic                      frame_done,
  output logic                      locked,
  output logic                      err_line_len,
  output logic                      err_frame,
  output logic [15:0]               measured_h_total,
  output logic [15:0]               measured_v_total
);

  localparam logic [15:0] HV    = 16'(hori_visible_area);
  localparam logic [15:0] VV    = 16'(vert_visible_area);
  localparam logic [31:0] HW    = 32'(hori_visible_area);
  localparam logic [31:0] DEPTH = 32'(RAM_depth);
  localparam logic        INACT = ~sync_polarity;

  typedef enum logic {SEARCH, CAPTURE} state_t;

  state_t state_q, state_d;

  logic                 s1_de, s2_de;
  logic                 s1_h, s2_h;
  logic                 s1_v, s2_v;
  logic [RAM_width-1:0] s1_pix;

  logic [15:0] x_q, y_q, x_e, y_e;
  logic [31:0] base_q, addr_q, base_e, addr_e;
  logic        line_err_q;
  logic [1:0]  good_cnt;
  logic [15:0] h_cnt, v_cnt;

  logic hs_edge, vs_edge, de_fall;
  logic cap, wr, line_end, line_bad;
  logic frame_end, frame_good, frame_bad_y;

  // Only the top RAM_width bits of a pixel are stored.
  logic unused_pix;
  assign unused_pix = ^vid_data;

  function automatic logic [15:0] inc_sat(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign hs_edge = (s1_h == sync_polarity) && (s2_h != sync_polarity);
  assign vs_edge = (s1_v == sync_polarity) && (s2_v != sync_polarity);
  assign de_fall = s2_de && !s1_de;
  assign locked  = (good_cnt == 2'd2);

  // A VSYNC edge restarts position before this cycle's pixel is placed.
  always_comb begin
    state_d = state_q;
    x_e     = x_q;
    y_e     = y_q;
    base_e  = base_q;
    addr_e  = addr_q;
    if (vs_edge) begin
      state_d = capture_en ? CAPTURE : SEARCH;
      x_e     = '0;
      y_e     = '0;
      base_e  = '0;
      addr_e  = '0;
    end
    cap         = (state_d == CAPTURE);
    wr          = cap && s1_de && (x_e < HV) &&
                  (y_e < VV) && (addr_e < DEPTH);
    line_end    = cap && de_fall && !vs_edge;
    line_bad    = line_end && (x_q != HV);
    frame_end   = vs_edge && (state_q == CAPTURE);
    frame_good  = frame_end && (y_q == VV) && !line_err_q;
    frame_bad_y = frame_end && (y_q != VV);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_de             <= 1'b0;
      s2_de             <= 1'b0;
      s1_h              <= INACT;
      s2_h              <= INACT;
      s1_v              <= INACT;
      s2_v              <= INACT;
      s1_pix            <= '0;
      state_q           <= SEARCH;
      x_q               <= '0;
      y_q               <= '0;
      base_q            <= '0;
      addr_q            <= '0;
      line_err_q        <= 1'b0;
      good_cnt          <= '0;
      framebuffer_we    <= 1'b0;
      framebuffer_addr  <= '0;
      framebuffer_wdata <= '0;
      frame_done        <= 1'b0;
      err_line_len      <= 1'b0;
      err_frame         <= 1'b0;
      h_cnt             <= '0;
      v_cnt             <= '0;
      measured_h_total  <= '0;
      measured_v_total  <= '0;
    end else begin
      s1_de  <= vid_de;
      s2_de  <= s1_de;
      s1_h   <= vid_h;
      s2_h   <= s1_h;
      s1_v   <= vid_v;
      s2_v   <= s1_v;
      s1_pix <= vid_data[23 -: RAM_width];

      state_q           <= state_d;
      framebuffer_we    <= wr;
      framebuffer_addr  <= addr_e[RAM_depth_bits-1:0];
      framebuffer_wdata <= s1_pix;
      frame_done        <= frame_good;

      x_q    <= x_e;
      y_q    <= y_e;
      base_q <= base_e;
      addr_q <= addr_e;
      if (cap && s1_de) begin
        x_q    <= inc_sat(x_e);
        addr_q <= addr_e + 32'd1;
      end else if (line_end) begin
        // Each line restarts at its own row base, even after a short line.
        x_q    <= '0;
        y_q    <= inc_sat(y_q);
        base_q <= base_q + HW;
        addr_q <= base_q + HW;
      end

      if (vs_edge)
        line_err_q <= 1'b0;
      else if (line_bad)
        line_err_q <= 1'b1;

      if (frame_good)
        good_cnt <= (good_cnt == 2'd2) ? good_cnt : good_cnt + 2'd1;
      else if (frame_end)
        good_cnt <= '0;

      err_line_len <= (err_line_len && !err_clear) || line_bad;
      err_frame    <= (err_frame && !err_clear) || frame_bad_y;

      if (hs_edge) begin
        measured_h_total <= h_cnt;
        h_cnt            <= 16'd1;
      end else begin
        h_cnt <= inc_sat(h_cnt);
      end

      if (vs_edge) begin
        measured_v_total <= v_cnt;
        v_cnt            <= {15'd0, hs_edge};
      end else if (hs_edge) begin
        v_cnt <= inc_sat(v_cnt);
      end
    end
  end

endmodule

// File: tb/tb_dvi_capture.sv
// tb_dvi_capture: randomized frames against a frame-level scoreboard model
// of dvi_capture (16x4 window, 64-word RAM, 8-bit words, active-low sync).
module tb_dvi_capture;

  localparam int H  = 16;
  localparam int V  = 4;
  localparam int D  = 64;
  localparam int W  = 8;
  localparam int AB = 6;
  localparam int HT = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          vid_de;
  logic          vid_h;
  logic          vid_v;
  logic [23:0]   vid_data;
  logic          capture_en;
  logic          err_clear;
  logic [AB-1:0] fb_addr;
  logic [W-1:0]  fb_wdata;
  logic          fb_we;
  logic          frame_done;
  logic          locked;
  logic          err_line_len;
  logic          err_frame;
  logic [15:0]   mh;
  logic [15:0]   mv;

  dvi_capture #(
    .hori_visible_area(H),
    .vert_visible_area(V),
    .sync_polarity(1'b0),
    .RAM_width(W),
    .RAM_depth(D),
    .RAM_depth_bits(AB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .vid_de(vid_de),
    .vid_h(vid_h),
    .vid_v(vid_v),
    .vid_data(vid_data),
    .capture_en(capture_en),
    .err_clear(err_clear),
    .framebuffer_addr(fb_addr),
    .framebuffer_wdata(fb_wdata),
    .framebuffer_we(fb_we),
    .frame_done(frame_done),
    .locked(locked),
    .err_line_len(err_line_len),
    .err_frame(err_frame),
    .measured_h_total(mh),
    .measured_v_total(mv)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int addr;
    int data;
    int at;
  } wr_t;

  wr_t exp_q[$];
  int  fd_q[$];
  wr_t mon_e;
  int  fd_at;
  int  total = 0;
  int  bad = 0;

  bit m_cap = 0;
  bit m_line_bad = 0;
  bit m_err_l = 0;
  bit m_err_f = 0;
  int m_lines = 0;
  int m_good = 0;

  task automatic chk(input string tag, input int got, input int want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (fb_we === 1'b1) begin
      total++;
      assert (exp_q.size() > 0) else begin
        bad++;
        $error("FAIL stray_write addr=%0d want=none", fb_addr);
      end
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        total += 3;
        assert (int'(fb_addr) === mon_e.addr) else begin
          bad++;
          $error("FAIL wr_addr got=%0d want=%0d", fb_addr, mon_e.addr);
        end
        assert (int'(fb_wdata) === mon_e.data) else begin
          bad++;
          $error("FAIL wr_data got=%0d want=%0d", fb_wdata, mon_e.data);
        end
        assert (cyc === mon_e.at) else begin
          bad++;
          $error("FAIL wr_cycle got=%0d want=%0d", cyc, mon_e.at);
        end
      end
    end
    if (frame_done === 1'b1) begin
      total++;
      assert (fd_q.size() > 0) else begin
        bad++;
        $error("FAIL stray_frame_done cycle=%0d want=none", cyc);
      end
      if (fd_q.size() > 0) begin
        fd_at = fd_q.pop_front();
        total++;
        assert (cyc === fd_at) else begin
          bad++;
          $error("FAIL frame_done_cycle got=%0d want=%0d", cyc, fd_at);
        end
      end
    end
  end

  // Frame-end verdict for the frame that this VSYNC edge closes.
  task automatic vs_event();
    if (m_cap) begin
      if (m_lines == V && !m_line_bad) begin
        fd_q.push_back(cyc + 2);
        if (m_good < 2) m_good++;
      end else begin
        if (m_lines != V) m_err_f = 1;
        m_good = 0;
      end
    end
    m_cap = capture_en;
    m_lines = 0;
    m_line_bad = 0;
  endtask

  task automatic drive_line(input bit vs, input int len,
                            input bit addr_pix, input int rst_x);
    int  x;
    int  a;
    wr_t e;
    for (int t = 0; t < HT; t++) begin
      @(negedge clk);
      rst = 1'b0;
      vid_h = (t >= 2);
      vid_v = !vs;
      if (vs && t == 0) vs_event();
      x = t - 4;
      vid_de = (x >= 0 && x < len);
      vid_data = 24'($urandom());
      if (vid_de) begin
        a = m_lines * H + x;
        if (addr_pix) vid_data[23:16] = 8'(a);
        if (m_cap && x < H && m_lines < V && a < D) begin
          e.addr = a;
          e.data = int'(vid_data[23:16]);
          e.at = cyc + 2;
          exp_q.push_back(e);
        end
        if (x == rst_x) begin
          #1 chk("we_before_rst", int'(fb_we), 1);
          #1 rst = 1'b1;
          #1 chk("we_drop_on_rst", int'(fb_we), 0);
          while (exp_q.size() > 0 && exp_q[$].at > cyc)
            void'(exp_q.pop_back());
          m_cap = 0;
          m_good = 0;
          m_err_l = 0;
          m_err_f = 0;
          m_line_bad = 0;
        end
      end
    end
    if (len > 0) begin
      if (m_cap && len != H) begin
        m_line_bad = 1;
        m_err_l = 1;
      end
      m_lines++;
    end
  endtask

  task automatic check_status();
    chk("locked", int'(locked), int'(m_good == 2));
    chk("err_line_len", int'(err_line_len), int'(m_err_l));
    chk("err_frame", int'(err_frame), int'(m_err_f));
  endtask

  task automatic send_frame(input int n, input int short_y,
                            input int short_len, input bit addr_pix,
                            input int drop_y, input int rst_y);
    drive_line(1'b1, 0, addr_pix, -1);
    check_status();
    for (int y = 0; y < n; y++) begin
      drive_line(1'b0, (y == short_y) ? short_len : H, addr_pix,
                 (y == rst_y) ? 5 : -1);
      if (y == drop_y) capture_en = 1'b0;
    end
    drive_line(1'b0, 0, addr_pix, -1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    vid_de = 1'b0;
    vid_h = 1'b1;
    vid_v = 1'b1;
    vid_data = '0;
    capture_en = 1'b1;
    err_clear = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_we", int'(fb_we), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_err_line_len", int'(err_line_len), 0);
    chk("rst_err_frame", int'(err_frame), 0);
    chk("rst_addr", int'(fb_addr), 0);
    chk("rst_h_total", int'(mh), 0);
    chk("rst_v_total", int'(mv), 0);

    repeat (3) send_frame(4, -1, 0, 1'b1, -1, -1);
    chk("h_total", int'(mh), HT);
    chk("v_total", int'(mv), V + 2);

    send_frame(4, 1, 15, 1'b0, -1, -1);
    send_frame(5, -1, 0, 1'b0, -1, -1);
    send_frame(4, -1, 0, 1'b0, 1, -1);
    send_frame(4, -1, 0, 1'b0, -1, -1);

    @(negedge clk) err_clear = 1'b1;
    @(negedge clk) err_clear = 1'b0;
    @(negedge clk);
    m_err_l = 0;
    m_err_f = 0;
    chk("clr_err_line_len", int'(err_line_len), int'(m_err_l));
    chk("clr_err_frame", int'(err_frame), int'(m_err_f));

    capture_en = 1'b1;
    send_frame(4, -1, 0, 1'b0, -1, 2);
    send_frame(4, -1, 0, 1'b0, -1, -1);
    send_frame(0, -1, 0, 1'b0, -1, -1);
    repeat (4) @(negedge clk);
    chk("pending_writes", exp_q.size(), 0);
    chk("pending_frame_done", fd_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
